display_refresh_ctrl: RTL and testbench

Refresh scheduler in front of `display2048`. It arbitrates two board sources for the single OLED drawing engine:
- requester A: the game core's live board;
- requester B: the overlay/test-pattern source.

For each grant it snapshots the chosen 64-bit nibble board and holds it stable on the engine's `NUMS` input. It then pulses `REFRESH` and tracks the engine's `BUSY` through one full redraw. It rate-limits, skips redundant redraws and times out a dead engine.

---
 rtl/display_refresh_ctrl.sv | 176 +++++++++++++++++
 tb/tb_display_refresh_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_refresh_ctrl.sv
// display_refresh_ctrl
// Refresh scheduler that feeds one OLED drawing engine (display2048) from two
// board sources. On each grant it snapshots the winner's 64-bit nibble board
// onto DISP_NUMS, pulses DISP_REFRESH and follows DISP_BUSY through a redraw.
// Redraws are rate-limited by MIN_GAP. A redraw is skipped when the same
// source offers the board already on screen. A dead engine is detected by
// START_TIMEOUT.
//
// Handshake: each requester raises *_REQ and holds it, with a stable board,
// until its *_ACK pulses for one cycle. The ACK means "snapshot taken" or
// "redraw skipped". A REQ dropped before its ACK is a withdrawal, and no
// grant is made for it.
//
// Ports
//   CLK, ASYNC_RST_L      clock, asynchronous active-low reset
//   A_REQ/A_NUMS/A_ACK    requester A (game core), priority source
//   B_REQ/B_NUMS/B_ACK    requester B (overlay / test pattern)
//   DISP_NUMS             board held for the engine, changes only on a grant
//   DISP_REFRESH          redraw strobe to the engine
//   DISP_BUSY             engine busy (drawing or initialising)
//   IDLE                  scheduler idle
//   ERR                   sticky: engine never acknowledged a refresh
module display_refresh_ctrl #(
  parameter logic [19:0] MIN_GAP       = 20'd50000,
  parameter logic [15:0] START_TIMEOUT = 16'd1024
) (
  input  logic        CLK,
  input  logic        ASYNC_RST_L,
  input  logic        A_REQ,
  input  logic [63:0] A_NUMS,
  output logic        A_ACK,
  input  logic        B_REQ,
  input  logic [63:0] B_NUMS,
  output logic        B_ACK,
  output logic [63:0] DISP_NUMS,
  output logic        DISP_REFRESH,
  input  logic        DISP_BUSY,
  output logic        IDLE,
  output logic        ERR
);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ISSUE, S_DRAW, S_GAP} state_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_A, SRC_B} src_e;

  state_e      state_q, state_d;
  src_e        last_src_q, last_src_d;
  logic [19:0] gap_q, gap_d;
  logic [15:0] tmo_q, tmo_d;
  logic [1:0]  streak_q, streak_d;
  logic [63:0] nums_q, nums_d;
  logic        refresh_q, refresh_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        err_q, err_d;

  logic        gap_zero;
  logic        pick_b;
  src_e        win_src;
  logic [63:0] win_nums;

  assign gap_zero = (gap_q == 20'd0);

  // B wins when A is absent, or when A has taken two grants in a row while B
  // was waiting (streak_q saturates at 2 through the ARB update below).
  always_comb begin
    pick_b   = B_REQ && (!A_REQ || (streak_q == 2'd2));
    win_src  = pick_b ? SRC_B : SRC_A;
    win_nums = pick_b ? B_NUMS : A_NUMS;
  end

  always_comb begin
    state_d    = state_q;
    last_src_d = last_src_q;
    gap_d      = gap_zero ? 20'd0 : gap_q - 20'd1;
    tmo_d      = tmo_q;
    streak_d   = streak_q;
    nums_d     = nums_q;
    refresh_d  = 1'b0;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if ((A_REQ || B_REQ) && !DISP_BUSY && gap_zero) state_d = S_ARB;
      end

      S_ARB: begin
        if (!A_REQ && !B_REQ) begin
          state_d = S_IDLE;  // request withdrawn before it could be granted
        end else begin
          a_ack_d = !pick_b;
          b_ack_d = pick_b;
          if (pick_b)     streak_d = 2'd0;
          else if (B_REQ) streak_d = streak_q + 2'd1;
          else            streak_d = 2'd0;
          if ((win_nums == nums_q) && (win_src == last_src_q)) begin
            // Same source, same picture: nothing new to draw, and the gap
            // counter is left alone.
            state_d = S_IDLE;
          end else begin
            nums_d     = win_nums;
            last_src_d = win_src;
            tmo_d      = 16'd0;
            state_d    = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        refresh_d = 1'b1;
        if (!refresh_q) begin
          // Strobe rises at the next edge. The rate limit is measured from
          // this rise, and BUSY is ignored until the strobe has been seen.
          gap_d = MIN_GAP;
        end else if (DISP_BUSY) begin
          refresh_d = 1'b0;
          state_d   = S_DRAW;
        end else if (tmo_q == START_TIMEOUT - 16'd1) begin
          // The engine never started, so the screen content is unknown.
          // Forget the source so the next request redraws in full.
          refresh_d  = 1'b0;
          err_d      = 1'b1;
          last_src_d = SRC_NONE;
          state_d    = S_GAP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      S_DRAW: begin
        if (!DISP_BUSY) state_d = S_GAP;
      end

      S_GAP: begin
        if (gap_zero) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
    if (!ASYNC_RST_L) begin
      state_q    <= S_IDLE;
      last_src_q <= SRC_NONE;
      gap_q      <= 20'd0;
      tmo_q      <= 16'd0;
      streak_q   <= 2'd0;
      nums_q     <= 64'd0;
      refresh_q  <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_src_q <= last_src_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      streak_q   <= streak_d;
      nums_q     <= nums_d;
      refresh_q  <= refresh_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      err_q      <= err_d;
    end
  end

  assign DISP_NUMS    = nums_q;
  assign DISP_REFRESH = refresh_q;
  assign A_ACK        = a_ack_q;
  assign B_ACK        = b_ack_q;
  assign ERR          = err_q;
  assign IDLE         = (state_q == S_IDLE);

endmodule

// File: tb/tb_display_refresh_ctrl.sv
// Bench for display_refresh_ctrl. The engine model answers DISP_REFRESH with
// a BUSY pulse after a programmable delay. It can also hold BUSY low (dead
// engine) or hold BUSY high (engine initialising). The reference model keeps
// a grant history and the source and board last put on screen.
module tb_display_refresh_ctrl;

  localparam logic [19:0] MIN_GAP       = 20'd300;
  localparam logic [15:0] START_TIMEOUT = 16'd40;
  localparam int          BUDGET        = 3000;

  logic        CLK = 1'b0;
  logic        ASYNC_RST_L;
  logic        A_REQ, B_REQ, DISP_BUSY;
  logic [63:0] A_NUMS, B_NUMS;
  logic        A_ACK, B_ACK, DISP_REFRESH, IDLE, ERR;
  logic [63:0] DISP_NUMS;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Engine model controls: 0 = normal, 1 = dead (BUSY low), 2 = BUSY held high.
  int eng_mode  = 0;
  int eng_delay = 5;
  int eng_len   = 40;

  // Reference model state.
  int          hist_src[$];
  bit          hist_bhi[$];
  int          shown_src;
  logic [63:0] shown_nums;
  int          prev_rise;
  bit          have_rise;

  display_refresh_ctrl #(
    .MIN_GAP      (MIN_GAP),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .CLK         (CLK),
    .ASYNC_RST_L (ASYNC_RST_L),
    .A_REQ       (A_REQ),
    .A_NUMS      (A_NUMS),
    .A_ACK       (A_ACK),
    .B_REQ       (B_REQ),
    .B_NUMS      (B_NUMS),
    .B_ACK       (B_ACK),
    .DISP_NUMS   (DISP_NUMS),
    .DISP_REFRESH(DISP_REFRESH),
    .DISP_BUSY   (DISP_BUSY),
    .IDLE        (IDLE),
    .ERR         (ERR)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- engine model ----------------
  initial begin
    DISP_BUSY = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      if (eng_mode == 2) DISP_BUSY = 1'b1;
      else if (eng_mode == 1) DISP_BUSY = 1'b0;
      else begin
        DISP_BUSY = 1'b0;
        if (DISP_REFRESH === 1'b1) begin
          repeat (eng_delay) begin @(posedge CLK); #2; end
          DISP_BUSY = 1'b1;
          repeat (eng_len) begin @(posedge CLK); #2; end
          DISP_BUSY = 1'b0;
        end
      end
    end
  end

  // ---------------- continuous checks ----------------
  // DISP_NUMS may only move in an ACK cycle (or under reset), and ACKs are exclusive.
  logic [63:0] prev_nums;
  initial begin
    prev_nums = 64'd0;
    forever begin
      step();
      if (ASYNC_RST_L === 1'b1 && A_ACK !== 1'b1 && B_ACK !== 1'b1)
        check_eq("nums_stable", DISP_NUMS, prev_nums);
      check_eq("ack_exclusive", 64'(A_ACK & B_ACK), 64'd0);
      prev_nums = DISP_NUMS;
    end
  end

  // ---------------- reference model ----------------
  function automatic int predict();
    int  n;
    bit  starve;
    n      = hist_src.size();
    starve = (n >= 2) && (hist_src[n-1] == 1) && (hist_src[n-2] == 1) &&
             hist_bhi[n-1] && hist_bhi[n-2];
    if (B_REQ && (starve || !A_REQ)) return 2;
    if (A_REQ) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    hist_src.delete();
    hist_bhi.delete();
    shown_src  = 0;
    shown_nums = 64'd0;
    have_rise  = 1'b0;
  endtask

  // Serve one grant with the current REQ levels. exp_lat > 0 checks the
  // cycles to ACK; stuck selects the dead-engine expectation.
  task automatic run_grant(input bit keep, input int exp_lat, input bit stuck, output int src);
    int          waited, pred, w;
    logic [63:0] board;
    bit          skip, bhi;
    pred   = predict();
    bhi    = B_REQ;
    src    = 0;
    waited = 0;
    while (src == 0 && waited < BUDGET) begin
      step();
      waited++;
      if (A_ACK === 1'b1) src = 1;
      else if (B_ACK === 1'b1) src = 2;
    end
    check_eq("ack_seen", 64'(src != 0), 64'd1);
    if (src == 0) return;
    check_eq("grant_src", 64'(src), 64'(pred));
    if (exp_lat > 0) check_eq("ack_latency", 64'(waited), 64'(exp_lat));
    board = (src == 1) ? A_NUMS : B_NUMS;
    skip  = (src == shown_src) && (board == shown_nums);
    hist_src.push_back(src);
    hist_bhi.push_back(bhi);
    check_eq("snapshot", DISP_NUMS, board);
    if (src == 1) begin
      if (keep) A_NUMS = rnd64(); else A_REQ = 1'b0;
    end else begin
      if (keep) B_NUMS = rnd64(); else B_REQ = 1'b0;
    end
    step();
    check_eq("ack_one_cycle", 64'({A_ACK, B_ACK}), 64'd0);
    if (skip) check_eq("skip_no_refresh", 64'(DISP_REFRESH), 64'd0);
    else      check_eq("refresh_rise", 64'(DISP_REFRESH), 64'd1);
    if (skip || DISP_REFRESH !== 1'b1) return;
    if (have_rise)
      check_eq("min_gap", 64'((cyc - prev_rise) >= int'(MIN_GAP)), 64'd1);
    prev_rise  = cyc;
    have_rise  = 1'b1;
    shown_src  = src;
    shown_nums = board;
    w = 0;
    while (DISP_REFRESH === 1'b1 && w <= int'(START_TIMEOUT) + 4) begin
      w++;
      step();
    end
    if (stuck) begin
      check_eq("refresh_width_timeout", 64'(w), 64'(START_TIMEOUT));
      check_eq("err_set", 64'(ERR), 64'd1);
      shown_src = 0;
    end else begin
      check_eq("refresh_width", 64'(w), 64'(eng_delay + 1));
    end
  endtask

  // Wait until the scheduler can grant at once (idle, engine free, gap expired).
  task automatic settle();
    int n;
    n = 0;
    while ((IDLE !== 1'b1 || DISP_BUSY !== 1'b0 ||
            (have_rise && cyc < prev_rise + int'(MIN_GAP) + 2)) && n < BUDGET) begin
      step();
      n++;
    end
    check_eq("settle", 64'(n < BUDGET), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  int          s;
  int          k;
  logic [63:0] keep_board;
  logic [63:0] pool [3];

  initial begin
    ASYNC_RST_L = 1'b0;
    A_REQ = 1'b0; B_REQ = 1'b0;
    A_NUMS = 64'd0; B_NUMS = 64'd0;
    prev_rise = 0;
    model_reset();

    // Reset values
    #3;
    check_eq("rst_nums", DISP_NUMS, 64'd0);
    check_eq("rst_refresh", 64'(DISP_REFRESH), 64'd0);
    check_eq("rst_acks", 64'({A_ACK, B_ACK}), 64'd0);
    check_eq("rst_idle", 64'(IDLE), 64'd1);
    check_eq("rst_err", 64'(ERR), 64'd0);
    repeat (2) @(posedge CLK);
    #1 ASYNC_RST_L = 1'b1;
    step();

    // Single draw: ACK two cycles after REQ, REFRESH one cycle later
    eng_delay = $urandom_range(3, 20);
    eng_len   = $urandom_range(30, 80);
    A_NUMS = 64'h0123_4567_89AB_0000;
    A_REQ  = 1'b1;
    run_grant(1'b0, 2, 1'b0, s);
    while (cyc < prev_rise + int'(MIN_GAP) - 2) step();
    check_eq("idle_during_gap", 64'(IDLE), 64'd0);
    while (cyc < prev_rise + int'(MIN_GAP) + 2) step();
    check_eq("idle_after_gap", 64'(IDLE), 64'd1);
    check_eq("err_clear", 64'(ERR), 64'd0);

    // Redundant skip: same board from the same source
    A_REQ = 1'b1;
    run_grant(1'b0, 2, 1'b0, s);
    repeat (3) step();
    check_eq("skip_stays_quiet", 64'(DISP_REFRESH), 64'd0);

    // Withdrawn request: REQ dropped before ACK
    A_NUMS = rnd64();
    A_REQ  = 1'b1;
    step();
    A_REQ  = 1'b0;
    repeat (4) begin
      step();
      check_eq("withdrawn_no_ack", 64'(A_ACK), 64'd0);
    end

    // A new board after a skip is served at once (gap not restarted)
    A_REQ = 1'b1;
    run_grant(1'b0, 2, 1'b0, s);

    // Contention with starvation guard: A, A, B, A, A, B
    settle();
    A_NUMS = rnd64(); B_NUMS = rnd64();
    A_REQ = 1'b1; B_REQ = 1'b1;
    for (int i = 0; i < 6; i++) begin
      eng_delay = $urandom_range(0, 20);
      run_grant(1'b1, 0, 1'b0, s);
      check_eq("grant_order", 64'(s), (i % 3 == 2) ? 64'd2 : 64'd1);
    end
    k = $urandom_range(0, 3);
    for (int i = 0; i < k; i++) begin
      eng_delay = $urandom_range(0, 20);
      run_grant(1'b1, 0, 1'b0, s);
    end
    A_REQ = 1'b0; B_REQ = 1'b0;
    check_eq("err_clear_contention", 64'(ERR), 64'd0);

    // Dead engine: REFRESH times out, ERR sticks, same board redraws
    settle();
    eng_mode   = 1;
    keep_board = rnd64();
    A_NUMS     = keep_board;
    A_REQ      = 1'b1;
    run_grant(1'b0, 2, 1'b1, s);
    eng_mode = 0;
    settle();
    check_eq("err_sticky", 64'(ERR), 64'd1);
    A_NUMS = keep_board;
    A_REQ  = 1'b1;
    eng_delay = $urandom_range(0, 20);
    run_grant(1'b0, 2, 1'b0, s);
    check_eq("timeout_redraw_src", 64'(s), 64'd1);
    check_eq("err_still_set", 64'(ERR), 64'd1);

    // Reset in the middle of a redraw
    settle();
    eng_len = 200;
    keep_board = rnd64();
    A_NUMS = keep_board;
    A_REQ  = 1'b1;
    run_grant(1'b0, 2, 1'b0, s);
    repeat (5) step();
    ASYNC_RST_L = 1'b0;
    #1;
    check_eq("midreset_nums", DISP_NUMS, 64'd0);
    check_eq("midreset_refresh", 64'(DISP_REFRESH), 64'd0);
    check_eq("midreset_err", 64'(ERR), 64'd0);
    check_eq("midreset_idle", 64'(IDLE), 64'd1);
    check_eq("midreset_acks", 64'({A_ACK, B_ACK}), 64'd0);
    step();
    step();
    ASYNC_RST_L = 1'b1;
    model_reset();
    A_NUMS = keep_board;
    A_REQ  = 1'b1;
    run_grant(1'b0, 0, 1'b0, s);
    check_eq("post_reset_redraw_src", 64'(s), 64'd1);
    eng_len = $urandom_range(30, 80);

    // Engine initialising: BUSY high out of reset holds off the grant
    settle();
    eng_mode = 2;
    step(); step();
    ASYNC_RST_L = 1'b0;
    step(); step();
    ASYNC_RST_L = 1'b1;
    model_reset();
    A_NUMS = rnd64();
    A_REQ  = 1'b1;
    k = $urandom_range(10, 30);
    repeat (k) begin
      step();
      check_eq("init_no_ack", 64'(A_ACK), 64'd0);
    end
    check_eq("init_idle", 64'(IDLE), 64'd1);
    eng_mode = 0;
    run_grant(1'b0, 2, 1'b0, s);

    // Random mix from a small board pool so skips occur
    pool[0] = rnd64(); pool[1] = rnd64(); pool[2] = rnd64();
    for (int i = 0; i < 10; i++) begin
      if (A_REQ !== 1'b1 && $urandom_range(0, 1) == 1) begin
        A_NUMS = pool[$urandom_range(0, 2)];
        A_REQ  = 1'b1;
      end
      if (B_REQ !== 1'b1 && $urandom_range(0, 1) == 1) begin
        B_NUMS = pool[$urandom_range(0, 2)];
        B_REQ  = 1'b1;
      end
      if (A_REQ !== 1'b1 && B_REQ !== 1'b1) begin
        A_NUMS = pool[$urandom_range(0, 2)];
        A_REQ  = 1'b1;
      end
      eng_delay = $urandom_range(0, 20);
      run_grant(1'b0, 0, 1'b0, s);
    end
    A_REQ = 1'b0; B_REQ = 1'b0;
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
